// File: rtl/imem_fetch_sequencer_if.sv
// Loader, core front-end and instruction-memory signals of the fetch sequencer.
// The sequencer uses the master modport. The loader, core and memory side uses the slave modport.
interface imem_fetch_sequencer_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
);
    logic              load_valid;
    logic [WIDTH-1:0]  load_data;
    logic              load_last;
    logic              load_ready;
    logic              fetch_req;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              reload;
    logic              fetch_valid;
    logic [WIDTH-1:0]  fetch_instr;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W:0]   prog_len;
    logic              running;
    logic              fault;
    logic              mem_wr_enable;
    logic              mem_rd_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;

    modport master (
        input  load_valid, load_data, load_last, fetch_req, jump_en, jump_addr, reload, mem_rdata,
        output load_ready, fetch_valid, fetch_instr, fetch_pc, prog_len, running, fault,
               mem_wr_enable, mem_rd_enable, mem_addr, mem_wdata
    );

    modport slave (
        output load_valid, load_data, load_last, fetch_req, jump_en, jump_addr, reload, mem_rdata,
        input  load_ready, fetch_valid, fetch_instr, fetch_pc, prog_len, running, fault,
               mem_wr_enable, mem_rd_enable, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// Time-shares instruction_mem between boot-load writes (LOAD) and PC-driven fetches (RUN); IMEM_BOUNDS_CHECK_EN adds jump bounds faults.
// Latency: a write lands in the cycle it is accepted; a fetch returns fetch_valid one cycle after fetch_req.
// Backpressure: load_ready is high only in LOAD and low during reset; fetches are never stalled and reload drops any fetch in flight.
module imem_fetch_sequencer #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    imem_fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1
`ifdef IMEM_BOUNDS_CHECK_EN
        , ST_FAULT = 2'd2
`endif
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W:0]   prog_len_q;
    logic              fetch_valid_q;
    logic              running_q;
    logic              load_ready_c;
    logic              load_acc;
    logic              jump_oob;
    logic              rd_en;
    logic              at_end;
    logic [ADDR_W-1:0] rd_addr;

    assign load_ready_c = (state == ST_LOAD) && !reset;
    assign load_acc     = bus.load_valid && load_ready_c;
    assign rd_addr      = bus.jump_en ? bus.jump_addr : pc;
`ifdef IMEM_BOUNDS_CHECK_EN
    assign jump_oob     = bus.jump_en && ({1'b0, bus.jump_addr} >= prog_len_q);
`else
    assign jump_oob     = 1'b0;
`endif
    assign rd_en        = (state == ST_RUN) && bus.fetch_req && !bus.reload && !jump_oob;
    // The PC wraps at the loaded program length, not at the memory depth.
    assign at_end       = ({1'b0, rd_addr} == (prog_len_q - (ADDR_W+1)'(1)));

    assign bus.load_ready    = load_ready_c;
    assign bus.mem_wr_enable = load_acc;
    assign bus.mem_rd_enable = rd_en;
    assign bus.mem_addr      = (state == ST_LOAD) ? wr_ptr : rd_addr;
    assign bus.mem_wdata     = bus.load_data;
    assign bus.fetch_instr   = bus.mem_rdata;
    assign bus.fetch_valid   = fetch_valid_q;
    assign bus.fetch_pc      = fetch_pc_q;
    assign bus.prog_len      = prog_len_q;
    assign bus.running       = running_q;

`ifdef IMEM_BOUNDS_CHECK_EN
    logic fault_q;
    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_LOAD;
            wr_ptr        <= '0;
            pc            <= '0;
            prog_len_q    <= '0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            running_q     <= 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            fetch_valid_q <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (load_acc) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        // A full memory ends the load even without load_last.
                        if (bus.load_last || (&wr_ptr)) begin
                            state      <= ST_RUN;
                            running_q  <= 1'b1;
                            prog_len_q <= {1'b0, wr_ptr} + 1'b1;
                            pc         <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.reload) begin
                        state     <= ST_LOAD;
                        running_q <= 1'b0;
                        wr_ptr    <= '0;
                        pc        <= '0;
                    end
`ifdef IMEM_BOUNDS_CHECK_EN
                    else if (jump_oob) begin
                        state     <= ST_FAULT;
                        running_q <= 1'b0;
                        fault_q   <= 1'b1;
                    end
`endif
                    else if (bus.fetch_req) begin
                        fetch_valid_q <= 1'b1;
                        fetch_pc_q    <= rd_addr;
                        pc            <= at_end ? '0 : rd_addr + 1'b1;
                    end else if (bus.jump_en) begin
                        pc <= bus.jump_addr;
                    end
                end
`ifdef IMEM_BOUNDS_CHECK_EN
                ST_FAULT: begin
                    if (bus.reload) begin
                        state   <= ST_LOAD;
                        fault_q <= 1'b0;
                        wr_ptr  <= '0;
                        pc      <= '0;
                    end
                end
`endif
                default: state <= ST_LOAD;
            endcase
        end
    end
endmodule
